// File: rtl/magic_nor_sequencer.sv
// MAGIC-style NOR micro-program executor over one modelled crossbar row.
// Loads inputs, runs one NOR per clock, returns a selected cell with done.
module magic_nor_sequencer #(
    parameter int NIN = 10,
    parameter int AW  = 6,
    parameter int IW  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_we,
    input  logic [IW-1:0]     prog_addr,
    input  logic [4*AW+2:0]   prog_data,
    input  logic [IW:0]       n_instr,
    input  logic              start,
    input  logic [NIN-1:0]    x_in,
    input  logic [AW-1:0]     out_addr,
    output logic              busy,
    output logic              done,
    output logic              z_out,
    output logic              err
);
    localparam int NC = 2**AW;
    localparam int PW = 4*AW+3;
    localparam logic [IW:0] NMAX = {1'b1, {IW{1'b0}}};
    localparam logic [AW-1:0] NIN_A = AW'(NIN);

    typedef enum logic [1:0] {IDLE, INIT, EXEC, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] pc_q, pc_d;
    logic [IW:0]   n_q, n_d;
    logic [NIN-1:0] x_q, x_d;
    logic [AW-1:0] oa_q, oa_d;
    logic [NC-1:0] cell_q, cell_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          z_q, z_d;
    logic          err_q, err_d;

    logic [PW-1:0] mem [2**IW];
    logic [PW-1:0] instr;
    logic [AW-1:0] dst, src_a, src_b, src_c;
    logic          en_a, en_b, en_c, nor_r;
    logic [IW:0]   n_sat;

    assign instr = mem[pc_q];
    assign dst   = instr[AW-1:0];
    assign src_a = instr[2*AW-1:AW];
    assign src_b = instr[3*AW-1:2*AW];
    assign src_c = instr[4*AW-1:3*AW];
    assign en_a  = instr[4*AW];
    assign en_b  = instr[4*AW+1];
    assign en_c  = instr[4*AW+2];

    // Sources come from cell_q, so src==dst naturally reads the old value.
    assign nor_r = ~((en_a & cell_q[src_a]) |
                     (en_b & cell_q[src_b]) |
                     (en_c & cell_q[src_c]));

    assign n_sat = (n_instr > NMAX) ? NMAX : n_instr;

    always_ff @(posedge clk) begin
        if (prog_we && state_q == IDLE) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        n_d     = n_q;
        x_d     = x_q;
        oa_d    = oa_q;
        cell_d  = cell_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        z_d     = z_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = n_sat;
                    x_d     = x_in;
                    oa_d    = out_addr;
                    err_d   = 1'b0;
                    pc_d    = '0;
                    busy_d  = 1'b1;
                    state_d = INIT;
                end
            end
            INIT: begin
                cell_d  = {{(NC-NIN){1'b1}}, x_q};
                state_d = (n_q == '0) ? DONE : EXEC;
            end
            EXEC: begin
                if (dst < NIN_A) begin
                    err_d = 1'b1;
                end else begin
                    cell_d[dst] = nor_r;
                end
                pc_d = pc_q + 1'b1;
                if ({1'b0, pc_q} == n_q - (IW+1)'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                z_d     = cell_q[oa_q];
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            n_q     <= '0;
            x_q     <= '0;
            oa_q    <= '0;
            cell_q  <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            n_q     <= n_d;
            x_q     <= x_d;
            oa_q    <= oa_d;
            cell_q  <= cell_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            z_q     <= z_d;
            err_q   <= err_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign z_out = z_q;
    assign err   = err_q;
endmodule

// File: doc/magic_nor_sequencer.md
Name: magic_nor_sequencer

Overview:
- Sequential executor for MAGIC-style NOR programs, i.e. the consumer of the NOR-only netlists the mapping flow emits.
- Holds a small NOR micro-program and a bit-cell array modelling one crossbar row.
- Loads primary inputs into the array, then executes one NOR micro-op per clock, as a MAGIC crossbar would.
- Returns a selected result cell with a done pulse. Used as a cycle-accurate golden executor and as the controller front end for crossbar evaluation.

Parameters:
- NIN, 10, number of primary inputs; occupy cells 0..NIN-1.
- AW, 6, cell address width; array has 2**AW cells.
- IW, 6, instruction address width; program memory has 2**IW entries.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- prog_we  input  1  program memory write strobe
- prog_addr  input  IW  program write address
- prog_data  input  4*AW+3  instruction word
- n_instr  input  IW+1  instruction count; sampled on accepted start
- start  input  1  begin a run; accepted only in IDLE
- x_in  input  NIN  primary input vector; sampled on accepted start
- out_addr  input  AW  result cell select; sampled on accepted start
- busy  output  1  high from the accepted start through the last EXEC cycle
- done  output  1  one-cycle pulse when the result is valid
- z_out  output  1  value of the selected cell; held until the next done
- err  output  1  sticky illegal-write flag; cleared on accepted start

Behaviour:
- Instruction word fields:
  - [AW-1:0] dst
  - [2AW-1:AW] srcA
  - [3AW-1:2AW] srcB
  - [4AW-1:3AW] srcC
  - bit 4AW = enA, bit 4AW+1 = enB, bit 4AW+2 = enC
- NOR semantics: result = ~(enA&cell[srcA] | enB&cell[srcB] | enC&cell[srcC]).
  - No enables set gives constant 1 (MAGIC output-cell init).
  - One enable set gives NOT.
- Reset: FSM enters IDLE; busy=0, done=0, z_out=0, err=0.
  - Cell array is set to all 1.
  - Program memory is not reset.
- prog_we writes prog_data to prog_addr only in IDLE. Writes in any other state are ignored.
- FSM states: IDLE, INIT, EXEC, DONE.
- IDLE: on start go to INIT.
  - Latch n_instr, x_in, out_addr; clear err; clear the PC; busy=1.
- INIT (1 cycle): cells 0..NIN-1 = x_in; all other cells = 1.
  - If n_instr==0 go to DONE, else go to EXEC.
- EXEC: one instruction per cycle at the PC.
  - cell[dst] gets the NOR result at the clock edge; PC increments.
  - After instruction n_instr-1, go to DONE.
  - Sources read pre-edge values. If src==dst, the old value is used.
  - Instruction k sees every write made by instructions 0..k-1.
- Illegal write: dst < NIN is suppressed (input cell unchanged), sets err, and execution continues.
- DONE (1 cycle): done=1, z_out = cell[latched out_addr], busy=0; then IDLE.
- Latency: start accepted at edge t, INIT at t+1, instruction k executes at edge t+2+k, done is high in the cycle after edge t+2+N.
- n_instr values above 2**IW saturate to 2**IW.
- start while busy is ignored and does not re-latch inputs.
- Asynchronous reset mid-run aborts immediately; no done is produced.

Test Plan:
- Reset, then load program {dst=10, srcA=0, enA} with n_instr=1, x_in=10'b0000000001, out_addr=10, start → busy=1 for 3 cycles; done pulses 3 cycles after start; z_out=0; err=0.
- OR via NOR-NOR: instr0 {dst=10, A=5, B=9, enA, enB}, instr1 {dst=11, A=10, enA}, out_addr=11.
  - x5=1, x9=0 → z_out=1.
  - Rerun with x_in=0 → z_out=0. Verifies read-after-write across consecutive instructions.
- 3-input NOR {dst=12, A=3, B=7, C=8, all enabled}, out_addr=12.
  - x3=x7=x8=0 → z_out=1.
  - x8=1 → z_out=0.
  - Also a zero-enable instruction to dst=13 with out_addr=13 → z_out=1.
- Illegal write {dst=2, A=0, enA}, x_in=all-ones, out_addr=2 → err=1; z_out=1 (cell unchanged).
  - Next start clears err.
- n_instr=0, out_addr=4, x4=1 → done exactly 2 cycles after start; z_out=1.
- Mid-run events on a 20-instruction run:
  - Pulse start at EXEC cycle 5 → run is unaffected.
  - prog_we during the run → memory unchanged.
  - Assert rst_n=0 at EXEC cycle 7 → busy=0, done never pulses, z_out=0, FSM in IDLE.
